// File: rtl/pe_data_fetch_store.sv
// pe_data_fetch_store: local operand/result memory between the control unit
// and the four processing elements. Streams BURST-word operand blocks onto
// the PE lanes, collects four-lane results into a circular result region,
// and exposes a host port for preload and readback.
//
// state  | meaning
// IDLE   | waiting; host writes accepted; a queued store is launched from here
// FETCH  | cnt 0..BURST-1 issue operand reads, cnt BURST drains the last word
// STORE  | cnt 0..3 write latched lanes 0..3 to the result slot at ptr
module pe_data_fetch_store #(
  parameter int BURST      = 16,
  parameter int DEPTH      = 512,
  parameter int STORE_BASE = 256,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           ADDR_START,
  input  logic           ADDR_RST,
  input  logic [3:0]     ADDRESS,
  input  logic [1:0]     PE_SEL,
  input  logic           PE_SEL_2x2,
  input  logic           PE_SEL_4,
  output logic           FETCH_DONE,
  input  logic           WRADDR_START,
  output logic           STORE_DONE,
  input  logic [127:0]   DATAOUT,
  output logic [127:0]   DATAIN,
  output logic [3:0]     DATA_VALID,
  output logic           BUSY,
  input  logic           HOST_WE,
  input  logic [AW-1:0]  HOST_ADDR,
  input  logic [31:0]    HOST_WDATA,
  output logic [31:0]    HOST_RDATA
);

  localparam int KW    = $clog2(BURST);
  localparam int CW    = $clog2(BURST + 1);
  localparam int NSLOT = (DEPTH - STORE_BASE) / 4;
  localparam int PW    = $clog2(NSLOT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_STORE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      addr_q, addr_d;
  logic [3:0]      mask_q, mask_d;
  logic            pend_q, pend_d;
  logic [127:0]    sdata_q, sdata_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            ptr_clr_q, ptr_clr_d;
  logic [3:0]      valid_q, valid_d;
  logic            fdone_q, fdone_d;
  logic            sdone_q, sdone_d;

  logic [31:0]     mem [DEPTH];
  logic [31:0]     fetch_rdata_q;
  logic [31:0]     host_rdata_q;

  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [31:0]     mem_wdata;
  logic [3:0]      lane_mask;
  logic [PW-1:0]   ptr_inc;

  // Lane routing from the live select inputs; latched when a fetch is accepted.
  always_comb begin
    lane_mask = 4'b0000;
    if (PE_SEL_4) begin
      lane_mask = 4'b1111;
    end else if (PE_SEL_2x2) begin
      lane_mask = PE_SEL[1] ? 4'b1100 : 4'b0011;
    end else begin
      lane_mask = 4'b0001 << PE_SEL;
    end
  end

  assign ptr_inc = (ptr_q == PW'(NSLOT - 1)) ? '0 : ptr_q + 1'b1;

  // Next-state, memory port control and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    pend_d    = pend_q;
    sdata_d   = sdata_q;
    ptr_d     = ptr_q;
    ptr_clr_d = ptr_clr_q;
    valid_d   = 4'b0000;
    fdone_d   = 1'b0;
    sdone_d   = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;

    case (state_q)
      ST_IDLE: begin
        if (ADDR_RST) begin
          ptr_d = '0;
        end
        if (HOST_WE) begin
          mem_we    = 1'b1;
          mem_waddr = HOST_ADDR;
          mem_wdata = HOST_WDATA;
        end
        // A store left queued by an aborted fetch goes before any new request.
        if (pend_q) begin
          state_d = ST_STORE;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else if (ADDR_START) begin
          state_d = ST_FETCH;
          cnt_d   = '0;
          addr_d  = ADDRESS;
          mask_d  = lane_mask;
          if (WRADDR_START) begin
            pend_d  = 1'b1;
            sdata_d = DATAOUT;
          end
        end else if (WRADDR_START) begin
          state_d = ST_STORE;
          cnt_d   = '0;
          sdata_d = DATAOUT;
        end
      end

      ST_FETCH: begin
        if (ADDR_RST) begin
          ptr_d = '0;
        end
        if (WRADDR_START && !pend_q) begin
          pend_d  = 1'b1;
          sdata_d = DATAOUT;
        end
        if (ADDR_RST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q < CW'(BURST)) begin
          rd_en   = 1'b1;
          rd_addr = AW'({addr_q, cnt_q[KW-1:0]});
          valid_d = mask_q;
          fdone_d = (cnt_q == CW'(BURST - 1));
          cnt_d   = cnt_q + 1'b1;
        end else begin
          // Drain cycle: last word is on the lanes; hand straight over to a queued store.
          cnt_d = '0;
          if (pend_d) begin
            state_d = ST_STORE;
            pend_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_STORE: begin
        mem_we    = 1'b1;
        mem_waddr = AW'(STORE_BASE) + AW'({ptr_q, cnt_q[1:0]});
        mem_wdata = sdata_q[{cnt_q[1:0], 5'd0} +: 32];
        if (ADDR_RST) begin
          ptr_clr_d = 1'b1;
        end
        sdone_d = (cnt_q[1:0] == 2'd2);
        if (cnt_q[1:0] == 2'd3) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          ptr_d     = (ptr_clr_q || ADDR_RST) ? '0 : ptr_inc;
          ptr_clr_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control state and registered outputs, synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      mask_q    <= '0;
      pend_q    <= 1'b0;
      sdata_q   <= '0;
      ptr_q     <= '0;
      ptr_clr_q <= 1'b0;
      valid_q   <= '0;
      fdone_q   <= 1'b0;
      sdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      mask_q    <= mask_d;
      pend_q    <= pend_d;
      sdata_q   <= sdata_d;
      ptr_q     <= ptr_d;
      ptr_clr_q <= ptr_clr_d;
      valid_q   <= valid_d;
      fdone_q   <= fdone_d;
      sdone_q   <= sdone_d;
    end
  end

  // Memory array: one write port, registered fetch and host read ports (read-before-write).
  always_ff @(posedge CLK) begin
    if (mem_we && !RST) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (rd_en) begin
      fetch_rdata_q <= mem[rd_addr];
    end
    if (RST) begin
      host_rdata_q <= '0;
    end else begin
      host_rdata_q <= mem[HOST_ADDR];
    end
  end

  // Lane fan-out: unselected lanes and idle cycles present zero.
  always_comb begin
    DATAIN = '0;
    for (int i = 0; i < 4; i++) begin
      if (valid_q[i]) begin
        DATAIN[32*i +: 32] = fetch_rdata_q;
      end
    end
  end

  assign DATA_VALID = valid_q;
  assign FETCH_DONE = fdone_q;
  assign STORE_DONE = sdone_q;
  assign BUSY       = (state_q != ST_IDLE);
  assign HOST_RDATA = host_rdata_q;

endmodule
